// File: rtl/param_deser.sv
// rtl/param_deser.sv - serial-to-parallel word deserializer with valid/ready output slot (optional PARAM_DESER_PARITY_EN)
module param_deser #(
    parameter int F = 7,
    parameter int K = 0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         d,
    input  logic         d_valid,
    input  logic         sof,
    output logic [F:K]   q,
    output logic         q_valid,
    input  logic         q_ready,
    output logic         overrun,
    input  logic         ovr_clr,
    output logic         q_perr
);

    localparam int W = F - K + 1;
`ifdef PARAM_DESER_PARITY_EN
    localparam int L = W + 1;
`else
    localparam int L = W;
`endif
    localparam int CW = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [W-1:0]  q_q, q_d;
    logic          q_valid_q, q_valid_d;
    logic          overrun_q, overrun_d;
    logic          q_perr_q, q_perr_d;

    logic          done;
    logic          can_load;
    logic          perr;
    logic [W-1:0]  word;
    logic [CW-1:0] pos;

    // Input side: place each accepted bit at its position; sof restarts the word at bit 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        done    = 1'b0;
        perr    = 1'b0;
        word    = sh_q;
        pos     = cnt_q;
        if (d_valid) begin
            if (sof || state_q == IDLE) begin
                pos  = '0;
                word = '0;
            end
            for (int i = 0; i < W; i++) begin
                if (CW'(i) == pos) begin
                    word[i] = d;
                end
            end
            if (pos == LAST) begin
                done    = 1'b1;
                cnt_d   = '0;
                sh_d    = '0;
                state_d = IDLE;
`ifdef PARAM_DESER_PARITY_EN
                // The trailing bit is parity only; odd parity over data plus parity bit
                perr    = ~(^word ^ d);
`endif
            end else begin
                cnt_d   = pos + CW'(1);
                sh_d    = word;
                state_d = SHIFT;
            end
        end
    end

    // Output slot: load when empty or being drained this cycle, otherwise drop and flag
    always_comb begin
        can_load  = !q_valid_q || q_ready;
        q_d       = q_q;
        q_valid_d = q_valid_q;
        q_perr_d  = q_perr_q;
        overrun_d = overrun_q;
        if (done && can_load) begin
            q_d       = word;
            q_valid_d = 1'b1;
            q_perr_d  = perr;
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end
        if (done && !can_load) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Assembly state registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // Output slot and sticky overrun registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_perr_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_perr_q  <= q_perr_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_perr  = q_perr_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_param_deser.sv
// tb/tb_param_deser.sv - self-checking bench for param_deser (table, directed and random vs reference model)
module tb_param_deser;

    localparam int W = 8;
`ifdef PARAM_DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int L = W + PAR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn = 1'b0, d = 1'b0, dv = 1'b0, sof = 1'b0, rdy = 1'b0, clr = 1'b0;
    logic [7:0] q;
    logic       qv, ovr, perr;

    logic       b_d = 1'b0, b_dv = 1'b0, b_sof = 1'b0, b_rdy = 1'b1, b_clr = 1'b0;
    logic [3:3] b_q;
    logic       b_qv, b_ovr, b_perr;

    param_deser #(.F(7), .K(0)) dut_a (
        .clk(clk), .rstn(rstn), .d(d), .d_valid(dv), .sof(sof),
        .q(q), .q_valid(qv), .q_ready(rdy), .overrun(ovr), .ovr_clr(clr), .q_perr(perr)
    );

    param_deser #(.F(3), .K(3)) dut_b (
        .clk(clk), .rstn(rstn), .d(b_d), .d_valid(b_dv), .sof(b_sof),
        .q(b_q), .q_valid(b_qv), .q_ready(b_rdy), .overrun(b_ovr), .ovr_clr(b_clr), .q_perr(b_perr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a bit list per word, a one-entry slot and a sticky flag
    bit         mbits[$];
    logic [7:0] m_q = 8'h00;
    logic       m_v = 1'b0, m_ovr = 1'b0, m_perr = 1'b0;

    task automatic model_step(input logic r, input logic dd, input logic v, input logic s,
                              input logic rd, input logic c);
        int   ones;
        int   wv;
        logic done;
        logic pe;
        logic can;
        if (!r) begin
            mbits.delete();
            m_q = 8'h00; m_v = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
            return;
        end
        done = 1'b0; pe = 1'b0; wv = 0;
        if (v) begin
            if (s) mbits.delete();
            mbits.push_back(dd);
            if (mbits.size() == L) begin
                ones = 0;
                for (int i = 0; i < W; i++) wv = wv + (int'(mbits[i]) * (1 << i));
                for (int i = 0; i < L; i++) ones = ones + int'(mbits[i]);
                pe = (PAR == 1) && (ones % 2 == 0);
                done = 1'b1;
                mbits.delete();
            end
        end
        can = !m_v || rd;
        if (done && !can) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        if (done && can) begin
            m_q = 8'(wv); m_v = 1'b1; m_perr = pe;
        end else if (m_v && rd) begin
            m_v = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic dd, input logic v, input logic s,
                        input logic rd, input logic c);
        rstn = r; d = dd; dv = v; sof = s; rdy = rd; clr = c;
        model_step(r, dd, v, s, rd, c);
        @(posedge clk);
        #1;
        check("model_q_valid", qv, m_v);
        check("model_overrun", ovr, m_ovr);
        if (m_v) begin
            check("model_q", q, m_q);
            check("model_q_perr", perr, m_perr);
        end
    endtask

    // Sends W data bits LSB first, plus a correct odd-parity bit when parity is enabled
    task automatic send_word(input logic [7:0] w, input logic rd_body, input logic rd_last,
                             input logic s_first, input logic clr_last);
        logic b;
        for (int i = 0; i < L; i++) begin
            b = (i < W) ? w[i] : ~(^w);
            step(1'b1, b, 1'b1, (i == 0) && s_first,
                 (i == L - 1) ? rd_last : rd_body, (i == L - 1) && clr_last);
        end
    endtask

    task automatic step_b(input logic bit_in);
        b_d = bit_in; b_dv = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef PARAM_DESER_PARITY_EN
        b_d = ~bit_in;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        b_dv = 1'b0;
        check("w1_q_valid", b_qv, 1'b1);
        check("w1_q", b_q, bit_in);
    endtask

    typedef struct {
        logic       drain;
        logic [7:0] w;
        logic       rd;
        logic [7:0] eq;
        logic       ev;
        logic       eovr;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{drain: 1'b1, w: 8'h4D, rd: 1'b1, eq: 8'h4D, ev: 1'b1, eovr: 1'b0};
        tbl[1] = '{drain: 1'b1, w: 8'hA5, rd: 1'b0, eq: 8'hA5, ev: 1'b1, eovr: 1'b0};
        tbl[2] = '{drain: 1'b0, w: 8'h3C, rd: 1'b0, eq: 8'hA5, ev: 1'b1, eovr: 1'b1};
        tbl[3] = '{drain: 1'b0, w: 8'h01, rd: 1'b1, eq: 8'h01, ev: 1'b1, eovr: 1'b1};
        tbl[4] = '{drain: 1'b0, w: 8'h02, rd: 1'b1, eq: 8'h02, ev: 1'b1, eovr: 1'b1};

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_q", q, 8'h00);
        check("rst_q_valid", qv, 1'b0);
        check("rst_overrun", ovr, 1'b0);
        check("rst_q_perr", perr, 1'b0);
        check("rst_w1_q_valid", b_qv, 1'b0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].drain) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            send_word(tbl[i].w, tbl[i].rd, tbl[i].rd, 1'b0, 1'b0);
            check("tbl_q", q, tbl[i].eq);
            check("tbl_q_valid", qv, tbl[i].ev);
            check("tbl_overrun", ovr, tbl[i].eovr);
        end

        // Accept pending word and clear overrun together
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("clr_overrun", ovr, 1'b0);
        check("clr_q_valid", qv, 1'b0);

        // Back-to-back: accept on the completing cycle of the next word
        send_word(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b_first_q", q, 8'h01);
        send_word(8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
        check("b2b_second_q", q, 8'h02);
        check("b2b_q_valid", qv, 1'b1);
        check("b2b_overrun", ovr, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("b2b_drained", qv, 1'b0);

        // Drop and ovr_clr in the same cycle: set wins
        send_word(8'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b1);
        check("drop_clr_overrun", ovr, 1'b1);
        check("drop_clr_q", q, 8'h11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("drop_clr_after", ovr, 1'b0);

        // sof aborts a partial word
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0);
        check("sof_q", q, 8'hFF);
        check("sof_q_valid", qv, 1'b1);
        check("sof_overrun", ovr, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word with a pending word
        send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("midrst_q_valid", qv, 1'b0);
        check("midrst_q", q, 8'h00);
        send_word(8'h4D, 1'b1, 1'b1, 1'b0, 1'b0);
        check("midrst_next_q", q, 8'h4D);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Single-bit word instance
        step_b(1'b1);
        step_b(1'b0);
        step_b(1'b1);
        check("w1_overrun", b_ovr, 1'b0);

`ifdef PARAM_DESER_PARITY_EN
        for (int i = 0; i < W; i++) step(1'b1, 1'(8'h4D >> i), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("par_good_perr", perr, 1'b0);
        check("par_good_q", q, 8'h4D);
        for (int i = 0; i < W; i++) step(1'b1, 1'(8'h4D >> i), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("par_bad_perr", perr, 1'b1);
        check("par_bad_q", q, 8'h4D);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 199) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_deser.md
Name: param_deser

Overview:
- Serial-to-parallel front stage. Collects single-bit `d` samples into an [F:K] word.
- Presents the word on a valid/ready output bus that feeds directly into the parameterised `[f:k] d` input of the downstream paramtest-style consumers.
- Range parameters F/K match the consumer's, so the word width always agrees with the consumer's bus.
- Clean target for TMR triplication: a small FSM, a counter, a shift register, an output slot and a sticky flag.

Parameters:
- F, 7: MSB index of output word.
- K, 0: LSB index of output word. Requires F >= K; word width W = F-K+1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  synchronous active-low reset, sampled on rising clk.
- d  input  1  serial data bit.
- d_valid  input  1  `d` is a valid sample this cycle.
- sof  input  1  start-of-frame; qualified by d_valid; marks `d` as bit 0 of a new word.
- q  output  [F:K]  assembled word.
- q_valid  output  1  `q` holds an unconsumed word.
- q_ready  input  1  consumer accepts `q` when q_valid && q_ready.
- overrun  output  1  sticky: a completed word was dropped.
- ovr_clr  input  1  clears `overrun`.
- q_perr  output  1  parity error for the word on `q` (see Optional Feature).

Behaviour:
- Interface: one clock `clk`; reset `rstn` is synchronous and active-low.
- Reset (rstn=0 at a clk edge):
  - q=0, q_valid=0, overrun=0, q_perr=0.
  - Bit counter cnt=0, shift register=0, FSM=IDLE.
  - Reset mid-word discards the partial word. Reset with q_valid=1 discards the pending word.
- Bit order is LSB first: the i-th accepted bit of a word lands at q[K+i].
- FSM, input side:
  - IDLE: cnt=0. On d_valid, store bit 0 and set cnt=1. Go to SHIFT, or to COMPLETE handling immediately if W==1.
  - SHIFT: each d_valid stores the bit at position cnt and increments cnt. d_valid=0 holds all state, with no timeout.
  - Word completes on the d_valid cycle where cnt==W-1 (or W in parity mode). cnt wraps to 0 and the FSM returns to IDLE in the same edge.
  - sof && d_valid in any state: discard the partial word, store `d` as bit 0, set cnt=1. No flag is raised for the aborted word.
- Output slot:
  - A completed word is loaded into `q`, with q_valid=1, at the same edge as its last bit. q_valid is therefore visible the cycle after the last bit is presented: latency is 1 cycle.
  - Load is allowed when q_valid==0, or when q_valid && q_ready in that same cycle. Simultaneous accept and load gives back-to-back words with no bubble.
  - Otherwise the new word is dropped, `q` keeps the old word, and overrun=1 at the next edge.
  - q_valid && q_ready with no new word: q_valid=0 at the next edge. `q` keeps its value; it is don't-care when invalid.
  - q, q_valid and q_perr are registered outputs, with no combinational path from inputs.
- overrun:
  - Set by a drop; cleared by ovr_clr.
  - Same-cycle drop and ovr_clr: set wins, overrun=1.
- W==1: every d_valid bit is a complete word, and the SHIFT state is never entered.

Optional Feature:
- Macro: PARAM_DESER_PARITY_EN.
- Defined:
  - Each word carries one extra trailing bit (index W), so a word completes at cnt==W.
  - Odd parity is required over the W data bits plus the parity bit.
  - q_perr is loaded with the word: 1 if parity fails, else 0. The parity bit itself is not stored in q.
  - A dropped word's q_perr is discarded.
- Undefined: q_perr is tied to 0, and words are W bits long.

Test Plan:
- F=7,K=0; reset; send bits 1,0,1,1,0,0,1,0 with d_valid=1 and q_ready=1 -> q=8'h4D, q_valid=1 for one cycle, 1 cycle after the last bit; overrun=0.
- q_ready=0; send 0xA5 then 0x3C -> q stays 0xA5, overrun=1. Raise q_ready -> 0xA5 accepted, q_valid=0. Pulse ovr_clr -> overrun=0.
- q_ready=1, back-to-back words 0x01, 0x02 with accept on the completing cycle -> q_valid stays 1 across the boundary; q=0x01 then 0x02.
- Send 3 bits, then sof with d_valid and 8 bits of 0xFF -> single word 0xFF, no overrun. Separately, assert rstn=0 mid-word -> q_valid=0, and the next word assembles from bit 0.
- F=3,K=3 (W=1); d=1,0,1 with d_valid -> three words q=1,0,1.
- With PARAM_DESER_PARITY_EN: send 0x4D plus parity bit 1 (total ones = 5) -> q_perr=0. Send 0x4D plus parity bit 0 -> q_perr=1.
